// File: rtl/conv33_out_collector_if.sv
// Stream bundle between the conv33 compute output, the window collector and its consumer.
// The collector side uses the slave modport; whoever feeds sums and takes results uses master.
interface conv33_out_collector_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        frame_done;
  logic        overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, frame_done, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, frame_done, overflow
  );
endinterface

// File: rtl/conv33_out_collector.sv
// Crops raw 3x3 sums to positions with a complete window and queues them in a small FIFO.
// The raster counters keep moving even when a sample is dropped, so frame alignment survives overflow.
module conv33_out_collector #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  conv33_out_collector_if.slave bus
);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [AW1-1:0] FULL_CNT = AW1'(FIFO_DEPTH);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW1-1:0] count;
  logic [16:0]    mem [FIFO_DEPTH];
  logic           valid;
  logic           frame_end;
  logic           keep;
  logic           full;
  logic           pop;
  logic           push;
  logic           overflow_q;
  logic           frame_done_q;

  always_comb begin
    frame_end = (row == ROW_LAST) && (col == COL_LAST);
    keep      = bus.in_valid && (row >= RW'(2)) && (col >= CW'(2));
    valid     = (count != '0);
    full      = (count == FULL_CNT);
    pop       = valid && bus.out_ready;
    // A pop frees the slot this cycle, so a full FIFO can still take a push.
    push      = keep && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (bus.in_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {frame_end, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      overflow_q   <= overflow_q | (keep && full && !pop);
      frame_done_q <= bus.in_valid && frame_end;
    end
  end

  // Head fields are masked while empty so stale or uninitialised entries never leak out.
  assign bus.out_valid  = valid;
  assign bus.out_data   = valid ? mem[rd_ptr][15:0] : '0;
  assign bus.out_last   = valid & mem[rd_ptr][16];
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_conv33_out_collector.sv
// Drives a 4x4/depth-4 and an 8x3/depth-2 collector in lockstep and checks both
// every cycle against a queue-based model of the cropping and FIFO rules.
module tb_conv33_out_collector;
  localparam int W0 = 4, H0 = 4, D0 = 4;
  localparam int W1 = 8, H1 = 3, D1 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv33_out_collector_if bus0 ();
  conv33_out_collector_if bus1 ();

  conv33_out_collector #(.IMG_W(W0), .IMG_H(H0), .FIFO_DEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  conv33_out_collector #(.IMG_W(W1), .IMG_H(H1), .FIFO_DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int          pix[2];
  bit          ovf[2];
  bit          fd[2];
  logic [15:0] log0[$];
  logic [15:0] log1[$];
  logic [15:0] expq[$];

  function automatic int qsize(int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [16:0] qhead(int id);
    if (qsize(id) == 0) return '0;
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  task automatic checkOutput(input string tag, input int id,
                             input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL dut%0d %s observed=%0h expected=%0h", id, tag, obs, exp);
    end
  endtask

  // Model of one clock edge: pop the head if ready, then keep/drop the incoming sample.
  task automatic modelStep(input int id, input logic v, input logic [15:0] d, input logic r);
    int w, h, dep, row, col;
    w   = (id == 0) ? W0 : W1;
    h   = (id == 0) ? H0 : H1;
    dep = (id == 0) ? D0 : D1;
    if (qsize(id) > 0 && r) begin
      if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    fd[id] = 1'b0;
    if (v) begin
      row = pix[id] / w;
      col = pix[id] % w;
      if (row >= 2 && col >= 2) begin
        if (qsize(id) < dep) begin
          if (id == 0) q0.push_back({pix[id] == w*h-1, d});
          else         q1.push_back({pix[id] == w*h-1, d});
        end else begin
          ovf[id] = 1'b1;
        end
      end
      fd[id]  = (pix[id] == w*h-1);
      pix[id] = (pix[id] + 1) % (w*h);
    end
  endtask

  task automatic checkDut(input int id, input logic v, input logic [15:0] d,
                          input logic l, input logic o, input logic f);
    logic [16:0] hd;
    hd = qhead(id);
    checkOutput("out_valid",  id, 16'(v), 16'(qsize(id) > 0));
    checkOutput("out_data",   id, d,      hd[15:0]);
    checkOutput("out_last",   id, 16'(l), 16'(hd[16]));
    checkOutput("overflow",   id, 16'(o), 16'(ovf[id]));
    checkOutput("frame_done", id, 16'(f), 16'(fd[id]));
  endtask

  task automatic checkAll();
    checkDut(0, bus0.out_valid, bus0.out_data, bus0.out_last, bus0.overflow, bus0.frame_done);
    checkDut(1, bus1.out_valid, bus1.out_data, bus1.out_last, bus1.overflow, bus1.frame_done);
  endtask

  task automatic applyStimulus(input logic v0, input logic [15:0] d0, input logic r0,
                               input logic v1, input logic [15:0] d1, input logic r1);
    bus0.in_valid = v0; bus0.in_data = d0; bus0.out_ready = r0;
    bus1.in_valid = v1; bus1.in_data = d1; bus1.out_ready = r1;
    if (bus0.out_valid && r0) log0.push_back(bus0.out_data);
    if (bus1.out_valid && r1) log1.push_back(bus1.out_data);
    modelStep(0, v0, d0, r0);
    modelStep(1, v1, d1, r1);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Reset is applied with a valid sample present; that sample must not be counted.
  task automatic doReset();
    reset = 1'b1;
    bus0.in_valid = 1'b1; bus0.in_data = 16'hBEEF; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_data = 16'hBEEF; bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin
      pix[i] = 0; ovf[i] = 1'b0; fd[i] = 1'b0;
    end
    checkAll();
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
  endtask

  task automatic checkLog0(input string tag);
    checkOutput({tag, ".count"}, 0, 16'(log0.size()), 16'(expq.size()));
    for (int i = 0; i < expq.size() && i < log0.size(); i++)
      checkOutput({tag, ".item"}, 0, log0[i], expq[i]);
  endtask

  initial begin
    logic [15:0] fr[16];
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    doReset();

    // Single frame, data = raster index, always ready.
    log0.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    expq = '{16'd10, 16'd11, 16'd14, 16'd15};
    checkLog0("frame_basic");

    // Same frame with idle cycles between samples.
    log0.delete();
    for (int i = 0; i < 32; i++)
      applyStimulus(i % 2 == 0, 16'(i / 2), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkLog0("frame_gapped");

    // Two back-to-back frames of random sums.
    log0.delete();
    expq.delete();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) fr[i] = 16'($urandom);
      expq.push_back(fr[10]); expq.push_back(fr[11]);
      expq.push_back(fr[14]); expq.push_back(fr[15]);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, fr[i], 1'b1, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkLog0("two_frames");

    // Small FIFO stalled for a whole 8x3 frame: 18,19 held, the rest dropped.
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'(i), 1'b0);
    checkOutput("stall.overflow", 1, 16'(bus1.overflow), 16'd1);
    log1.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("drain.count", 1, 16'(log1.size()), 16'd2);
    if (log1.size() == 2) begin
      checkOutput("drain.first",  1, log1[0], 16'd18);
      checkOutput("drain.second", 1, log1[1], 16'd19);
    end
    checkOutput("drain.empty", 1, 16'(bus1.out_valid), 16'd0);

    // Fill the 4-deep FIFO exactly, then push while full with a simultaneous pop.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i + 100), 1'b0, 1'b0, '0, 1'b0);
    checkOutput("full.valid",    0, 16'(bus0.out_valid), 16'd1);
    checkOutput("full.overflow", 0, 16'(bus0.overflow), 16'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(i + 200), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'd210, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("full_push_pop.overflow", 0, 16'(bus0.overflow), 16'd0);
    checkOutput("full_push_pop.head",     0, bus0.out_data, 16'd111);
    for (int i = 11; i < 16; i++) applyStimulus(1'b1, 16'(i + 200), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++)   applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Reset mid-frame with two kept samples still queued; nothing stale may appear.
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 16'(i + 300), 1'b0, 1'b0, '0, 1'b0);
    doReset();
    log0.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)  applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    expq = '{16'd10, 16'd11, 16'd14, 16'd15};
    checkLog0("after_reset");

    // Random traffic on both instances, with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) doReset();
      applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 2) == 0,
                    ($urandom % 4) != 0, 16'($urandom), ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
